// File: rtl/alu_seq.sv
// alu_seq: multi-cycle instruction sequencer around an external combinational
// ALU. Each instruction walks IDLE -> DECODE -> EXEC -> (MEM) -> WB and owns a
// 16 x 32-bit register file plus an NZCV flag register.
// Optional feature macro: ALU_SEQ_ZERO_R0_EN (R0 reads as zero, writes to R0 dropped).
module alu_seq #(
    parameter int NREGS = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [31:0] instr,
    output logic [3:0]  alu_cond,
    output logic [3:0]  alu_opcode,
    output logic        alu_sbit,
    output logic [2:0]  alu_srcontrol,
    output logic [15:0] alu_imvalue,
    output logic [31:0] alu_in1,
    output logic [31:0] alu_in2,
    output logic [3:0]  alu_inflags,
    input  logic [31:0] alu_result,
    input  logic [3:0]  alu_outflags,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        wb_valid,
    output logic [3:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        wb_we
);

    typedef enum logic [2:0] {S_IDLE, S_DECODE, S_EXEC, S_MEM, S_WB} state_t;

    localparam logic [3:0] OP_CMP = 4'b1000;
    localparam logic [3:0] OP_LDR = 4'b1001;
    localparam logic [3:0] OP_STR = 4'b1010;

    state_t      state_q, state_d;
    logic [31:0] instr_q;
    logic [31:0] regs_q [NREGS];
    logic [3:0]  flags_q;
    logic        cond_met_q, cond_met_d;
    logic        reg_write_d;
    logic        rd_blocked;

    logic        instr_ready_q;
    logic [3:0]  alu_cond_q, alu_opcode_q, alu_inflags_q;
    logic        alu_sbit_q;
    logic [2:0]  alu_srcontrol_q;
    logic [15:0] alu_imvalue_q;
    logic [31:0] alu_in1_q, alu_in2_q;
    logic        dmem_req_q, dmem_we_q;
    logic [31:0] dmem_addr_q, dmem_wdata_q;
    logic        wb_valid_q, wb_we_q;
    logic [3:0]  wb_rd_q;
    logic [31:0] wb_data_q;

    logic [31:0] rn_val, rm_val, rd_val;

    // Instruction fields of the word currently in flight
    logic [3:0] cond_w, op_w, rd_w, rn_w, rm_w;
    logic       sbit_w;
    assign cond_w = instr_q[31:28];
    assign op_w   = instr_q[27:24];
    assign sbit_w = instr_q[23];
    assign rd_w   = instr_q[19:16];
    assign rn_w   = instr_q[15:12];
    assign rm_w   = instr_q[11:8];

    assign instr_ready   = instr_ready_q;
    assign alu_cond      = alu_cond_q;
    assign alu_opcode    = alu_opcode_q;
    assign alu_sbit      = alu_sbit_q;
    assign alu_srcontrol = alu_srcontrol_q;
    assign alu_imvalue   = alu_imvalue_q;
    assign alu_in1       = alu_in1_q;
    assign alu_in2       = alu_in2_q;
    assign alu_inflags   = alu_inflags_q;
    assign dmem_req      = dmem_req_q;
    assign dmem_we       = dmem_we_q;
    assign dmem_addr     = dmem_addr_q;
    assign dmem_wdata    = dmem_wdata_q;
    assign wb_valid      = wb_valid_q;
    assign wb_rd         = wb_rd_q;
    assign wb_data       = wb_data_q;
    assign wb_we         = wb_we_q;

`ifdef ALU_SEQ_ZERO_R0_EN
    assign rd_blocked = (rd_w == 4'd0);
`else
    assign rd_blocked = 1'b0;
`endif

    // Register file read ports for rn, rm and rd (rd feeds store data)
    always_comb begin
        rn_val = '0;
        rm_val = '0;
        rd_val = '0;
        for (int i = 0; i < NREGS; i++) begin
            if (rn_w == 4'(i)) rn_val = regs_q[i];
            if (rm_w == 4'(i)) rm_val = regs_q[i];
            if (rd_w == 4'(i)) rd_val = regs_q[i];
        end
`ifdef ALU_SEQ_ZERO_R0_EN
        if (rn_w == 4'd0) rn_val = '0;
        if (rm_w == 4'd0) rm_val = '0;
        if (rd_w == 4'd0) rd_val = '0;
`endif
    end

    // Condition check against the flag register as it stands during DECODE
    always_comb begin
        cond_met_d = 1'b1;
        case (cond_w)
            4'b0001: cond_met_d = flags_q[2];
            4'b0010: cond_met_d = !flags_q[2] && (flags_q[3] == flags_q[0]);
            4'b0011: cond_met_d = !flags_q[2] && (flags_q[3] != flags_q[0]);
            4'b0100: cond_met_d = (flags_q[3] == flags_q[0]);
            4'b0101: cond_met_d = (flags_q[3] != flags_q[0]);
            4'b0110: cond_met_d = !flags_q[2] && flags_q[1];
            4'b0111: cond_met_d = !flags_q[1];
            4'b1000: cond_met_d = flags_q[1];
            default: cond_met_d = 1'b1;
        endcase
    end

    // Only executed ALU ops (0000-0111) and loads write a register
    assign reg_write_d = cond_met_q && (!op_w[3] || (op_w == OP_LDR)) && !rd_blocked;

    // Next-state logic; memory ops only detour through MEM when executed
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (instr_valid && instr_ready_q) state_d = S_DECODE;
            S_DECODE: state_d = S_EXEC;
            S_EXEC:   state_d = (cond_met_q && ((op_w == OP_LDR) || (op_w == OP_STR))) ? S_MEM : S_WB;
            S_MEM:    if (dmem_ack) state_d = S_WB;
            S_WB:     state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Accept handshake: latch the word on accept, ready only while waiting in IDLE
    always_ff @(posedge clk) begin
        if (reset) begin
            instr_q       <= '0;
            instr_ready_q <= 1'b0;
        end else begin
            instr_ready_q <= (state_d == S_IDLE);
            if (state_q == S_IDLE && instr_valid && instr_ready_q) instr_q <= instr;
        end
    end

    // ALU drive registers loaded at the end of DECODE, held until the next DECODE
    always_ff @(posedge clk) begin
        if (reset) begin
            alu_cond_q      <= '0;
            alu_opcode_q    <= '0;
            alu_sbit_q      <= 1'b0;
            alu_srcontrol_q <= '0;
            alu_imvalue_q   <= '0;
            alu_in1_q       <= '0;
            alu_in2_q       <= '0;
            alu_inflags_q   <= '0;
            cond_met_q      <= 1'b0;
        end else if (state_q == S_DECODE) begin
            alu_cond_q      <= cond_w;
            alu_opcode_q    <= op_w;
            alu_sbit_q      <= sbit_w;
            alu_srcontrol_q <= instr_q[22:20];
            alu_imvalue_q   <= instr_q[15:0];
            alu_in1_q       <= rn_val;
            alu_in2_q       <= rm_val;
            alu_inflags_q   <= flags_q;
            cond_met_q      <= cond_met_d;
        end
    end

    // Flag update at the end of EXEC for executed flag-setting ops and CMP
    always_ff @(posedge clk) begin
        if (reset) begin
            flags_q <= '0;
        end else if (state_q == S_EXEC && cond_met_q && (sbit_w || op_w == OP_CMP)) begin
            flags_q <= alu_outflags;
        end
    end

    // Data memory request: raised entering MEM, held stable until the ack edge
    always_ff @(posedge clk) begin
        if (reset) begin
            dmem_req_q   <= 1'b0;
            dmem_we_q    <= 1'b0;
            dmem_addr_q  <= '0;
            dmem_wdata_q <= '0;
        end else if (state_q == S_EXEC && state_d == S_MEM) begin
            dmem_req_q   <= 1'b1;
            dmem_we_q    <= (op_w == OP_STR);
            dmem_addr_q  <= rn_val + {24'd0, instr_q[7:0]};
            dmem_wdata_q <= (op_w == OP_STR) ? rd_val : '0;
        end else if (state_q == S_MEM && dmem_ack) begin
            dmem_req_q   <= 1'b0;
            dmem_we_q    <= 1'b0;
        end
    end

    // Retire pulse: result captured from the ALU (end of EXEC) or memory (ack edge)
    always_ff @(posedge clk) begin
        if (reset) begin
            wb_valid_q <= 1'b0;
            wb_we_q    <= 1'b0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
        end else begin
            wb_valid_q <= 1'b0;
            if ((state_q == S_EXEC || state_q == S_MEM) && state_d == S_WB) begin
                wb_valid_q <= 1'b1;
                wb_we_q    <= reg_write_d;
                wb_rd_q    <= rd_w;
                wb_data_q  <= (state_q == S_MEM) ? dmem_rdata : alu_result;
            end else if (state_q == S_WB) begin
                wb_we_q    <= 1'b0;
            end
        end
    end

    // Register file write on leaving WB, so the next DECODE already sees it
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else if (state_q == S_WB && wb_we_q) begin
            for (int i = 0; i < NREGS; i++) begin
                if (wb_rd_q == 4'(i)) regs_q[i] <= wb_data_q;
            end
        end
    end

endmodule
